// File: rtl/ifft_writeback_pkg.sv
// Shared types and constants for the IFFT write-back path.
// Holds the sample type, the write-back FSM state encoding and the
// input almost-full margin used by ifft_writeback.
package ifft_writeback_pkg;

   // One complex IFFT sample (Q-format real/imag pair).
   typedef struct packed {
      logic signed [15:0] re;
      logic signed [15:0] im;
   } complex_t;

   // Write-back job state.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } wb_state_t;

   // in_almostfull asserts when this many or fewer FIFO slots remain.
   localparam int ALMOST_FULL_MARGIN = 8;

endpackage

// File: rtl/ifft_writeback_fifo.sv
// wb_fifo: synchronous show-ahead FIFO buffering IFFT output cachelines.
// Latency: a push is visible on dout/empty the cycle after; pop consumes dout combinationally.
// Backpressure: none; push while full is ignored unless a pop occurs in the same cycle.
// Ports: clk/reset (sync, active-high), clr (synchronous flush), push/din,
//        pop/dout (head entry), count (occupancy), full, empty.
module wb_fifo #(
   parameter int WIDTH = 512,
   parameter int DEPTH = 64,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read behind a valid count.
   always_ff @(posedge clk) begin
      if (do_push && !clr) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/ifft_writeback.sv
// ifft_writeback: streams IFFT output cachelines to a contiguous memory region.
// Latency: in_valid at cycle t reaches wr_req_en at t+2; one write per cycle sustained.
// Backpressure: wr_req_almostfull stalls issue; input is push-only, in_almostfull is a hint,
//               and a push into a full FIFO is dropped and flagged on sticky overflow.
// Ports: start/dest_base_addr/num_cl_out launch a job; in_valid/in_data feed cachelines;
//        wr_req_* issue writes; wr_rsp0/1_* count completions; done/overflow report status.
module ifft_writeback
   import ifft_writeback_pkg::*;
#(
   parameter int ADDR_LMT    = 20,
   parameter int MDATA       = 14,
   parameter int CACHE_WIDTH = 512,
   parameter int FIFO_DEPTH  = 64
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [ADDR_LMT-1:0]    dest_base_addr,
   input  logic [31:0]            num_cl_out,
   input  logic                   in_valid,
   input  logic [CACHE_WIDTH-1:0] in_data,
   output logic                   in_almostfull,
   output logic [ADDR_LMT-1:0]    wr_req_addr,
   output logic [MDATA-1:0]       wr_req_mdata,
   output logic [CACHE_WIDTH-1:0] wr_req_data,
   output logic                   wr_req_en,
   input  logic                   wr_req_almostfull,
   input  logic                   wr_rsp0_valid,
   input  logic [MDATA-1:0]       wr_rsp0_mdata,
   input  logic                   wr_rsp1_valid,
   input  logic [MDATA-1:0]       wr_rsp1_mdata,
   output logic                   done,
   output logic                   overflow
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] AF_LEVEL = CW'(FIFO_DEPTH - ALMOST_FULL_MARGIN);

   wb_state_t              state_q, state_d;
   logic [31:0]            num_q, num_d;
   logic [ADDR_LMT-1:0]    base_q, base_d;
   logic [31:0]            issued_q, issued_d;
   logic [31:0]            compl_q, compl_d;
   logic                   overflow_q, overflow_d;
   logic                   done_q, done_d;
   logic                   in_af_q, in_af_d;
   logic                   wr_en_q, wr_en_d;
   logic [ADDR_LMT-1:0]    wr_addr_q, wr_addr_d;
   logic [MDATA-1:0]       wr_mdata_q, wr_mdata_d;
   logic [CACHE_WIDTH-1:0] wr_data_q, wr_data_d;

   logic                   fifo_clr;
   logic                   fifo_push;
   logic                   fifo_pop;
   logic [CACHE_WIDTH-1:0] fifo_dout;
   logic [CW-1:0]          fifo_count;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   active;

   // Completion tags are informational only.
   logic                   unused_rsp_mdata;
   assign unused_rsp_mdata = ^{wr_rsp0_mdata, wr_rsp1_mdata};

   wb_fifo #(
      .WIDTH (CACHE_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clr   (fifo_clr),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (in_data),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign active    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign fifo_pop  = (state_q == ST_RUN) && !fifo_empty && !wr_req_almostfull
                      && (issued_q < num_q);
   assign fifo_push = in_valid && active && (!fifo_full || fifo_pop);

   always_comb begin
      state_d    = state_q;
      num_d      = num_q;
      base_d     = base_q;
      issued_d   = issued_q;
      compl_d    = compl_q;
      overflow_d = overflow_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_mdata_d = wr_mdata_q;
      wr_data_d  = wr_data_q;
      fifo_clr   = 1'b0;

      if (active) begin
         compl_d = compl_q + 32'(wr_rsp0_valid) + 32'(wr_rsp1_valid);
         if (in_valid && fifo_full && !fifo_pop) overflow_d = 1'b1;
      end

      if (fifo_pop) begin
         issued_d   = issued_q + 32'd1;
         wr_en_d    = 1'b1;
         wr_addr_d  = base_q + issued_q[ADDR_LMT-1:0];
         wr_mdata_d = issued_q[MDATA-1:0];
         wr_data_d  = fifo_dout;
      end

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               num_d    = num_cl_out;
               base_d   = dest_base_addr;
               issued_d = '0;
               compl_d  = '0;
               fifo_clr = 1'b1;
               state_d  = (num_cl_out == 32'd0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            if (issued_q == num_q) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (compl_q >= num_q) state_d = ST_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Registered from the next state so done is high exactly while in DONE.
      done_d  = (state_d == ST_DONE);
      in_af_d = (fifo_count >= AF_LEVEL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         num_q      <= '0;
         base_q     <= '0;
         issued_q   <= '0;
         compl_q    <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
         in_af_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_mdata_q <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         num_q      <= num_d;
         base_q     <= base_d;
         issued_q   <= issued_d;
         compl_q    <= compl_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
         in_af_q    <= in_af_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_mdata_q <= wr_mdata_d;
         wr_data_q  <= wr_data_d;
      end
   end

   // Gating with reset kills a write already registered when reset arrives,
   // keeping wr_req_en low during the reset cycle itself.
   assign wr_req_en     = wr_en_q && !reset;
   assign wr_req_addr   = wr_addr_q;
   assign wr_req_mdata  = wr_mdata_q;
   assign wr_req_data   = wr_data_q;
   assign done          = done_q;
   assign overflow      = overflow_q;
   assign in_almostfull = in_af_q;

endmodule

// File: doc/ifft_writeback.md
IFFT_WRITEBACK -- requirements
Module: ifft_writeback

Interface
REQ-001 SHALL have parameters: ADDR_LMT, default 20, cacheline address width; MDATA, default 14, request metadata width; CACHE_WIDTH, default 512, data width; FIFO_DEPTH, default 64, buffered cachelines (power of 2).
REQ-002 SHALL have these ports, clock and reset first:
- clk  in  1  clock; reset reset, synchronous, active-high.
- reset  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that latches the job and begins it.
- dest_base_addr  in  ADDR_LMT  cacheline address of output region, sampled on start.
- num_cl_out  in  32  total cachelines to write, sampled on start.
- in_valid  in  1  IFFT output cacheline valid (push-only, no backpressure).
- in_data  in  CACHE_WIDTH  IFFT output cacheline.
- in_almostfull  out  1  throttle hint to upstream scheduler.
- wr_req_addr  out  ADDR_LMT  write address.
- wr_req_mdata  out  MDATA  write tag.
- wr_req_data  out  CACHE_WIDTH  write payload.
- wr_req_en  out  1  write request strobe.
- wr_req_almostfull  in  1  write channel cannot accept new requests.
- wr_rsp0_valid / wr_rsp1_valid  in  1 each  write completions, two channels.
- wr_rsp0_mdata / wr_rsp1_mdata  in  MDATA each  completion tags (informational).
- done  out  1  all num_cl_out writes completed.
- overflow  out  1  sticky error: input cacheline dropped.

Function
REQ-003 SHALL implement states IDLE, RUN, DRAIN, DONE.
- IDLE->RUN on start with num_cl_out!=0.
- IDLE->DONE on start with num_cl_out==0.
- RUN->DRAIN when the issued count reaches num_cl_out.
- DRAIN->DONE when the completion count reaches num_cl_out.
- DONE->RUN or DONE->DONE on a new start, using the same num_cl_out rule.
- start in RUN or DRAIN SHALL be ignored.
REQ-004 SHALL buffer in_data in a FIFO_DEPTH-entry synchronous FIFO. A push occurs on in_valid in RUN or DRAIN when count<FIFO_DEPTH, or when count==FIFO_DEPTH and a pop happens in the same cycle.
REQ-005 in_valid while the FIFO is full with no simultaneous pop SHALL drop the data and set overflow to 1; overflow stays set until reset. in_valid in IDLE or DONE SHALL be dropped without setting overflow.
REQ-006 in_almostfull SHALL be a registered output, 1 when FIFO count >= FIFO_DEPTH-8.
REQ-007 A pop/issue SHALL occur in RUN when the FIFO is non-empty, wr_req_almostfull==0 and issued<num_cl_out.
REQ-008 On a pop, the next cycle SHALL present:
- wr_req_en=1;
- wr_req_data = the popped entry;
- wr_req_addr = dest_base_addr + issued (modulo 2^ADDR_LMT);
- wr_req_mdata = issued[MDATA-1:0].
wr_req_en SHALL be 0 in every other cycle. Issued increments by 1 per pop.
REQ-009 Latency: in_valid at cycle t with an empty FIFO and no stall SHALL give wr_req_en at t+2. Back-to-back in_valid SHALL sustain one wr_req_en per cycle.
REQ-010 Completion count SHALL add wr_rsp0_valid + wr_rsp1_valid each cycle (+2 when both are high), counting only in RUN and DRAIN.
REQ-011 done SHALL be registered, 1 only in DONE, and cleared the cycle after an accepted start.
REQ-012 Entering RUN from start SHALL clear issued and completion counts and the FIFO. It SHALL NOT clear overflow.

Reset
REQ-013 On reset:
- state=IDLE, FIFO empty, all counts 0;
- wr_req_en=0, wr_req_addr=0, wr_req_mdata=0, wr_req_data=0;
- done=0, overflow=0, in_almostfull=0.
REQ-014 Reset asserted mid-job SHALL abort the job immediately with no further wr_req_en. Late write responses after reset SHALL be ignored.

Structure
REQ-015 The FSM state enum and the almost-full margin localparam (8) SHALL live in the shared package/common.vh alongside complex_t.
REQ-016 The FIFO SHALL be a separate sub-module wb_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, count, full, empty). The FSM, counters and request registers stay in ifft_writeback.

Verification
REQ-017 base=0x100, num=4, 4 in_valid back-to-back, no stalls, responses echoed -> wr_req_en on 4 consecutive cycles starting 2 cycles after the first push; addrs 0x100..0x103; mdata 0..3; data in order; done 1 after the 4th response.
REQ-018 num=6, wr_req_almostfull held high for 10 cycles during the burst -> no wr_req_en while it is high; all 6 writes issued afterwards in order; no overflow.
REQ-019 FIFO_DEPTH=64, wr_req_almostfull held high, 70 in_valid -> in_almostfull 1 once count>=56; overflow 1 after the 65th push; exactly 64 writes issued after release.
REQ-020 num=3; wr_rsp0_valid and wr_rsp1_valid both high in one cycle, then one more rsp0 -> completion count reaches 3; done asserts the following cycle.
REQ-021 start with num=0 -> done 1 the next cycle, no wr_req_en. Then start with num=2 -> done drops, 2 writes issued, done reasserts.
REQ-022 Reset pulse after 2 of 5 writes issued -> wr_req_en 0 from the reset cycle on; all outputs at reset values; subsequent in_valid ignored until start.
